dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Round-robin arbiter that shares the single-port 32-bit data memory between NUM_REQ requesters (e.g. TMR core replicas, a debug/load port). It serialises requests into one memory access per grant, drives the memory's WE/A/WD inputs from registered state, and returns registered read data with a per-requester valid pulse. Out-of-range addresses are rejected without touching memory.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
DEPTH, 32, number of memory words; valid word addresses are 0..DEPTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester access request (level)
we  input  NUM_REQ  per-requester write enable, qualified by req
addr  input  NUM_REQ*32  per-requester word address, slice i = [32*i+31:32*i]
wdata  input  NUM_REQ*32  per-requester write data, same slicing
gnt  output  NUM_REQ  one-hot one-cycle pulse: request accepted, memory access this cycle
rvalid  output  NUM_REQ  one-hot one-cycle pulse: access complete, rdata/err valid
rdata  output  32  registered read data (0 for writes and errors)
err  output  1  address out of range, valid with rvalid
mem_we  output  1  memory write enable
mem_a  output  32  memory word address
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data (combinational from mem_a)

Behaviour:
- Reset (rst low, async): state=IDLE, ptr=0, gnt=0, rvalid=0, rdata=0, err=0, mem_we=0, mem_a=0, mem_wd=0, latched id/we/addr/wdata=0.
- States: IDLE, ACCESS. ACCESS lasts exactly one cycle; ACCESS always returns to IDLE.
- IDLE: eligible = req & ~rvalid (requester whose rvalid is high this cycle is masked). If eligible!=0: winner = first set bit scanning ptr, ptr+1, ... wrapping mod NUM_REQ; at clock edge latch winner id, we[w], addr[w], wdata[w]; set gnt[w]=1, mem_a=addr[w], mem_wd=wdata[w]; set range_ok = (addr[w] < DEPTH); mem_we = we[w] & range_ok; ptr <= (w+1) mod NUM_REQ; go ACCESS. If eligible==0: all pulses 0, mem_we=0, mem_a/mem_wd hold.
- ACCESS: memory writes on the edge ending this cycle if mem_we=1. At that edge: rvalid[id]=1; rdata = (!we && range_ok) ? mem_rd : 0; err = !range_ok; gnt=0; mem_we=0; state IDLE.
- rvalid/err/rdata: rvalid and err are single-cycle pulses; rdata holds until next rvalid.
- Latency: req sampled in IDLE at edge N -> gnt high cycle N+1 -> rvalid/rdata high cycle N+2. Max throughput one access per 2 cycles.
- Requester contract: hold req/we/addr/wdata stable from req assertion until gnt seen; drop req in the rvalid cycle or later re-request. Inputs after latch are ignored.
- Fairness: any continuously requesting requester is granted within NUM_REQ grants.
- Simultaneous requests: round-robin from ptr only; no fixed priority.
- Reset mid-ACCESS: mem_we clears immediately (async), write is not performed, no rvalid issued.
- addr >= DEPTH: no write, no read; err=1, rdata=0 with rvalid.
- Address compare uses full 32-bit unsigned addr.

Test Plan:
- Single read: mem[2]=0x00000008, req[0]=1, we=0, addr=2 -> gnt[0] next cycle, rvalid[0] following cycle, rdata=0x00000008, err=0.
- Write then read: req[1] we=1 addr=4 wdata=0xDEADBEEF -> mem_we=1 only in gnt cycle, mem[4]=0xDEADBEEF; subsequent read by req[2] addr=4 returns 0xDEADBEEF.
- Round-robin: all three req held high from reset -> gnt order 0,1,2,0,1,2, gnt every other cycle, no requester skipped.
- Masking: req[0] held high through its rvalid cycle with req[1] high -> next grant to 1, not 0.
- Out-of-range: req[0] we=1 addr=32 wdata=0x1 -> mem_we stays 0, memory unchanged, rvalid[0]=1, err=1, rdata=0.
- Reset mid-access: assert rst low during ACCESS of a write to addr=3 -> mem_we drops immediately, mem[3] unchanged, all outputs 0, after release first grant goes to requester 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*32-1:0] addr;
  logic [NUM_REQ*32-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [31:0]           rdata;
  logic                  err;
  logic                  mem_we;
  logic [31:0]           mem_a;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  modport slave (
    input  req, we, addr, wdata, mem_rd,
    output gnt, rvalid, rdata, err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req, we, addr, wdata, mem_rd,
    input  gnt, rvalid, rdata, err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one single-port data memory.
// One access per grant, registered memory controls, registered read data and per-requester valid.
module dmem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus_io
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [31:0]    DEPTH_W   = 32'(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   id_q, id_d;
  logic               we_q, we_d;
  logic               ok_q, ok_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_a_q, mem_a_d;
  logic [31:0]        mem_wd_q, mem_wd_d;

  logic [31:0]        addr_w  [NUM_REQ];
  logic [31:0]        wdata_w [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_id;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_w[gi]  = bus_io.addr[32*gi +: 32];
    assign wdata_w[gi] = bus_io.wdata[32*gi +: 32];
  end

  // Modulo-NUM_REQ addition for requester indices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    logic [PTR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    return sum[PTR_W-1:0];
  endfunction

  // A requester whose result is being returned this cycle may not win again yet.
  assign eligible = bus_io.req & ~rvalid_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && eligible[wrap_add(ptr_q, PTR_W'(k))]) begin
        win_found = 1'b1;
        win_id    = wrap_add(ptr_q, PTR_W'(k));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    ok_d     = ok_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    mem_we_d = 1'b0;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d          = win_id;
          we_d          = bus_io.we[win_id];
          ok_d          = (addr_w[win_id] < DEPTH_W);
          gnt_d[win_id] = 1'b1;
          mem_a_d       = addr_w[win_id];
          mem_wd_d      = wdata_w[win_id];
          mem_we_d      = bus_io.we[win_id] && (addr_w[win_id] < DEPTH_W);
          ptr_d         = wrap_add(win_id, PTR_W'(1));
          state_d       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Memory completes on this edge; capture its read port for reads only.
        rvalid_d[id_q] = 1'b1;
        rdata_d        = (!we_q && ok_q) ? bus_io.mem_rd : 32'h0;
        err_d          = !ok_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      ok_q     <= ok_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mem_we_q <= mem_we_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  assign bus_io.gnt    = gnt_q;
  assign bus_io.rvalid = rvalid_q;
  assign bus_io.rdata  = rdata_q;
  assign bus_io.err    = err_q;
  assign bus_io.mem_we = mem_we_q;
  assign bus_io.mem_a  = mem_a_q;
  assign bus_io.mem_wd = mem_wd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests, a transaction-level model compared every cycle,
// plus literal expectations for latency, grant order, error handling and reset.
module tb_dmem_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NUM_REQ(N)) bus ();

  dmem_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Requester drive state
  logic [N-1:0]        req_v   = '0;
  logic [N-1:0]        we_v    = '0;
  logic [N-1:0][31:0]  addr_v  = '0;
  logic [N-1:0][31:0]  wdata_v = '0;
  assign bus.req   = req_v;
  assign bus.we    = we_v;
  assign bus.addr  = addr_v;
  assign bus.wdata = wdata_v;

  // Memory: unwritten word i reads as 4*i; writes use the raw low address bits.
  logic [31:0]      mem [DEPTH];
  bit [DEPTH-1:0]   mem_wr = '0;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_a[4:0]]    <= bus.mem_wd;
      mem_wr[bus.mem_a[4:0]] <= 1'b1;
    end
  end
  assign bus.mem_rd = mem_wr[bus.mem_a[4:0]] ? mem[bus.mem_a[4:0]]
                                             : {25'd0, bus.mem_a[4:0], 2'b00};

  function automatic logic [31:0] bench_word(input logic [4:0] i);
    return mem_wr[i] ? mem[i] : {25'd0, i, 2'b00};
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one pending access at a time, outputs derived from the rules.
  logic [31:0]    mmem [DEPTH];
  bit [DEPTH-1:0] mmask = '0;
  bit             m_busy = 1'b0;
  int             m_ptr = 0;
  int             m_id = 0;
  int             w = 0;
  bit             m_found = 1'b0;
  bit             m_w = 1'b0;
  bit             m_ok = 1'b0;
  logic [31:0]    m_a = '0;
  logic [31:0]    m_d = '0;
  logic [N-1:0]   elig = '0;
  logic [N-1:0]   e_gnt = '0;
  logic [N-1:0]   e_rvalid = '0;
  logic [31:0]    e_rdata = '0;
  logic           e_err = 1'b0;
  logic           e_mem_we = 1'b0;
  logic [31:0]    e_mem_a = '0;
  logic [31:0]    e_mem_wd = '0;

  function automatic logic [31:0] model_word(input logic [4:0] i);
    return mmask[i] ? mmem[i] : {25'd0, i, 2'b00};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_ptr = 0;
      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_err = 1'b0;
      e_mem_we = 1'b0; e_mem_a = '0; e_mem_wd = '0;
    end else if (m_busy) begin
      m_ok = (m_a < 32'(DEPTH));
      e_gnt = '0; e_mem_we = 1'b0;
      e_rvalid = '0; e_rvalid[m_id[1:0]] = 1'b1;
      e_err = !m_ok;
      e_rdata = (!m_w && m_ok) ? model_word(m_a[4:0]) : 32'h0;
      if (m_w && m_ok) begin
        mmem[m_a[4:0]] = m_d;
        mmask[m_a[4:0]] = 1'b1;
      end
      m_busy = 1'b0;
    end else begin
      elig = req_v & ~e_rvalid;
      e_rvalid = '0; e_err = 1'b0; e_gnt = '0; e_mem_we = 1'b0;
      m_found = 1'b0;
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (!m_found && elig[w[1:0]]) begin
          m_found = 1'b1;
          m_id = w;
        end
      end
      if (m_found) begin
        m_w = we_v[m_id[1:0]];
        m_a = addr_v[m_id[1:0]];
        m_d = wdata_v[m_id[1:0]];
        e_gnt[m_id[1:0]] = 1'b1;
        e_mem_a = m_a;
        e_mem_wd = m_d;
        e_mem_we = m_w && (m_a < 32'(DEPTH));
        m_ptr = (m_id + 1) % N;
        m_busy = 1'b1;
      end
    end
  end

  // Compare process; also logs grants (id and cycle number).
  int gnt_log[$];
  int gnt_cyc[$];
  int cyc = 0;
  always @(negedge clk) begin
    check("gnt",    32'(bus.gnt),    32'(e_gnt));
    check("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
    check("rdata",  bus.rdata,       e_rdata);
    check("err",    32'(bus.err),    32'(e_err));
    check("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
    check("mem_a",  bus.mem_a,       e_mem_a);
    check("mem_wd", bus.mem_wd,      e_mem_wd);
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        gnt_log.push_back(i);
        gnt_cyc.push_back(cyc);
      end
      if (bus.rvalid[i])
        $display("txn req=%0d rdata=0x%08h err=%0d t=%0t", i, bus.rdata, bus.err, $time);
    end
    cyc++;
  end

  task automatic drive(input int i, input bit r, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    req_v[i[1:0]]   = r;
    we_v[i[1:0]]    = wr;
    addr_v[i[1:0]]  = a;
    wdata_v[i[1:0]] = d;
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_rvalid(input int i, output int cycles);
    cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.rvalid[i[1:0]]) begin
        cycles = c;
        break;
      end
    end
    check("rvalid_seen", 32'(cycles > 0), 32'd1);
  endtask

  task automatic wait_gnt(input int i);
    int seen;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.gnt[i[1:0]]) begin
        seen = 1;
        break;
      end
    end
    check("gnt_seen", 32'(seen), 32'd1);
  endtask

  task automatic assert_rst();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  initial begin
    int lat;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_gnt",    32'(bus.gnt),    32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata",  bus.rdata,       32'h0);
    check("rst_mem_a",  bus.mem_a,       32'h0);

    // Single read of word 2
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd2, 32'h0);
    wait_rvalid(0, lat);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data",    bus.rdata, 32'h0000_0008);
    check("rd_err",     32'(bus.err), 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write by requester 1, read back by requester 2
    drive(1, 1'b1, 1'b1, 32'd4, 32'hDEAD_BEEF);
    wait_rvalid(1, lat);
    check("wr_rdata", bus.rdata, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wr_mem4", bench_word(5'd4), 32'hDEAD_BEEF);
    drive(2, 1'b1, 1'b0, 32'd4, 32'h0);
    wait_rvalid(2, lat);
    check("rb_data", bus.rdata, 32'hDEAD_BEEF);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);

    // Round-robin with all three held from reset
    assert_rst();
    drive(0, 1'b1, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(2, 1'b1, 1'b0, 32'd2, 32'h0);
    release_rst();
    repeat (13) @(negedge clk);
    check("rr_count", 32'(gnt_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) check("rr_order", 32'(gnt_log[i]), 32'(i % 3));
    for (int i = 1; i < 6; i++) check("rr_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
    drop_all();

    // Masking: requester 0 stays high through its rvalid cycle
    assert_rst();
    drive(0, 1'b1, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd1, 32'h0);
    release_rst();
    repeat (6) @(negedge clk);
    check("mask_first",  32'(gnt_log[0]), 32'd0);
    check("mask_second", 32'(gnt_log[1]), 32'd1);
    drop_all();

    // Lone requester held high: rvalid cycle masks it, so grants are 3 cycles apart
    assert_rst();
    drive(0, 1'b1, 1'b0, 32'd7, 32'h0);
    release_rst();
    repeat (8) @(negedge clk);
    check("lone_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd3);
    drop_all();
    repeat (3) @(negedge clk);

    // Out-of-range write, huge-address read, top valid address
    drive(0, 1'b1, 1'b1, 32'd32, 32'h0000_0001);
    wait_rvalid(0, lat);
    check("oor_err",   32'(bus.err), 32'd1);
    check("oor_rdata", bus.rdata, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("oor_mem0", bench_word(5'd0), 32'h0);
    drive(1, 1'b1, 1'b0, 32'h8000_0002, 32'h0);
    wait_rvalid(1, lat);
    check("big_err", 32'(bus.err), 32'd1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b1, 1'b0, 32'd31, 32'h0);
    wait_rvalid(2, lat);
    check("top_rdata", bus.rdata, 32'd124);
    check("top_err",   32'(bus.err), 32'd0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the middle of a write access
    drive(0, 1'b1, 1'b1, 32'd3, 32'h0000_CAFE);
    wait_gnt(0);
    check("mid_we_before", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_we_after",  32'(bus.mem_we), 32'd0);
    check("mid_gnt_after", 32'(bus.gnt),    32'd0);
    drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
    drive(2, 1'b1, 1'b0, 32'd5, 32'h0);
    release_rst();
    wait_rvalid(0, lat);
    check("post_first",  32'(gnt_log[0]), 32'd0);
    check("post_rdata",  bus.rdata, 32'd12);
    check("post_mem3",   bench_word(5'd3), 32'd12);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_rvalid(2, lat);
    check("post_rdata2", bus.rdata, 32'd20);
    drop_all();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
